uart_mmio_fifo: RTL and testbench

- Memory-mapped direct-serial UART peripheral on txd/rxd.
- Replaces the fixed 9600-baud async_receiver/async_transmitter echo pair.
- Parametrised clock frequency, baud rate and FIFO depth; runtime-programmable divisor and parity.
- Hangs on the CPU data bus beside the RAM wrappers; drives one bit of the CPU int_i vector.

---
 rtl/uart_mmio_fifo.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_uart_mmio_fifo.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART with TX/RX FIFOs, programmable divisor and parity.
// Bus reads are combinational; the interrupt request is a registered level.
module uart_mmio_fifo #(
    parameter int CLK_FREQ   = 11059200,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  sel_i,
    output logic [31:0] data_o,
    output logic        int_o,
    output logic        txd,
    input  logic        rxd
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(CLK_FREQ / BAUD);
    localparam logic [DIV_W-1:0] ONE     = 1;
    localparam logic [DIV_W-1:0] DIV_MIN = 2;
    localparam logic [AW:0]      PTR_ONE = 1;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT} rx_state_t;

    // ---------------- bus decode and registers ----------------
    logic [1:0]       word;
    logic             wr_data, wr_stat, wr_ctrl, wr_div, rd_data;
    logic [3:0]       ctrl;
    logic [DIV_W-1:0] div, div_merge;
    logic             rx_overrun, frame_err, parity_err;
    logic             unused;

    assign word    = addr_i[3:2];
    assign wr_data = ce_i & we_i & (word == 2'd0) & sel_i[0];
    assign wr_stat = ce_i & we_i & (word == 2'd1) & sel_i[0];
    assign wr_ctrl = ce_i & we_i & (word == 2'd2) & sel_i[0];
    assign wr_div  = ce_i & we_i & (word == 2'd3) & (|sel_i[1:0]);
    assign rd_data = ce_i & ~we_i & (word == 2'd0);
    assign unused  = ^{addr_i[1:0], data_i[31:DIV_W], sel_i[3:2]};

    always_comb begin
        div_merge = div;
        if (sel_i[0]) div_merge[7:0] = data_i[7:0];
        if (sel_i[1]) div_merge[DIV_W-1:8] = data_i[DIV_W-1:8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl <= '0;
            div  <= DIV_RST;
        end else begin
            if (wr_ctrl) ctrl <= data_i[3:0];
            if (wr_div)  div  <= (div_merge < DIV_MIN) ? DIV_MIN : div_merge;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0] tx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wp, tx_rp;
    logic        tx_empty, tx_full, tx_push, tx_pop;
    logic [7:0]  tx_head;

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign tx_push  = wr_data & (~tx_full | tx_pop);
    assign tx_head  = tx_mem[tx_rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PTR_ONE;
            if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= data_i[7:0];
    end

    // ---------------- TX FSM ----------------
    tx_state_t        tx_state, tx_state_n;
    logic [DIV_W-1:0] tx_cnt, tx_div;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic             tx_pen, tx_par, tx_end, tx_idle;

    assign tx_end  = (tx_cnt == tx_div - ONE);
    assign tx_idle = tx_empty & (tx_state == TX_IDLE);

    always_comb begin
        tx_state_n = tx_state;
        tx_pop     = 1'b0;
        case (tx_state)
            TX_IDLE:  if (!tx_empty) begin
                          tx_pop     = 1'b1;
                          tx_state_n = TX_START;
                      end
            TX_START: if (tx_end) tx_state_n = TX_DATA;
            TX_DATA:  if (tx_end && tx_bit == 3'd7) tx_state_n = tx_pen ? TX_PAR : TX_STOP;
            TX_PAR:   if (tx_end) tx_state_n = TX_STOP;
            TX_STOP:  if (tx_end) begin
                          // Chain straight into the next frame when more data is queued.
                          if (!tx_empty) begin
                              tx_pop     = 1'b1;
                              tx_state_n = TX_START;
                          end else begin
                              tx_state_n = TX_IDLE;
                          end
                      end
            default:  tx_state_n = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_div   <= DIV_RST;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_pen   <= 1'b0;
            tx_par   <= 1'b0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            if (tx_pop) begin
                tx_shift <= tx_head;
                tx_div   <= div;
                tx_pen   <= ctrl[2];
                tx_par   <= (^tx_head) ^ ctrl[3];
                tx_cnt   <= '0;
                tx_bit   <= '0;
                txd      <= 1'b0;
            end else if (tx_state != TX_IDLE) begin
                if (tx_end) begin
                    tx_cnt <= '0;
                    case (tx_state)
                        TX_START: txd <= tx_shift[0];
                        TX_DATA: begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_shift <= tx_shift >> 1;
                            if (tx_bit == 3'd7) txd <= tx_pen ? tx_par : 1'b1;
                            else                txd <= tx_shift[1];
                        end
                        default:  txd <= 1'b1;
                    endcase
                end else begin
                    tx_cnt <= tx_cnt + ONE;
                end
            end
        end
    end

    // ---------------- RX synchroniser ----------------
    logic [1:0] rx_sync;
    logic       rx_s, rx_prev, rx_fall;

    assign rx_s    = rx_sync[1];
    assign rx_fall = rx_prev & ~rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], rxd};
            rx_prev <= rx_s;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0] rx_mem [FIFO_DEPTH];
    logic [AW:0] rx_wp, rx_rp;
    logic        rx_nonempty, rx_full, rx_push_req, rx_push, rx_pop, set_ovr;
    logic [7:0]  rx_head, rx_shift;

    assign rx_nonempty = (rx_wp != rx_rp);
    assign rx_full     = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign rx_pop      = rd_data & rx_nonempty;
    assign rx_push     = rx_push_req & (~rx_full | rx_pop);
    assign set_ovr     = rx_push_req & rx_full & ~rx_pop;
    assign rx_head     = rx_mem[rx_rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + PTR_ONE;
            if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_shift;
    end

    // ---------------- RX FSM ----------------
    rx_state_t        rx_state, rx_state_n;
    logic [DIV_W-1:0] rx_cnt, rx_div;
    logic [2:0]       rx_bit;
    logic             rx_pen, rx_podd, rx_end, rx_mid, set_frm, set_par;

    assign rx_end = (rx_cnt == rx_div - ONE);
    assign rx_mid = (rx_cnt == (rx_div >> 1) - ONE);

    always_comb begin
        rx_state_n  = rx_state;
        rx_push_req = 1'b0;
        set_frm     = 1'b0;
        set_par     = 1'b0;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_state_n = RX_START;
            RX_START: if (rx_mid) rx_state_n = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_end && rx_bit == 3'd7) rx_state_n = rx_pen ? RX_PAR : RX_STOP;
            RX_PAR:   if (rx_end) begin
                          rx_state_n = RX_STOP;
                          set_par    = rx_s != ((^rx_shift) ^ rx_podd);
                      end
            RX_STOP:  if (rx_end) begin
                          if (rx_s) begin
                              rx_push_req = 1'b1;
                              rx_state_n  = RX_IDLE;
                          end else begin
                              set_frm    = 1'b1;
                              rx_state_n = RX_WAIT;
                          end
                      end
            RX_WAIT:  if (rx_s) rx_state_n = RX_IDLE;
            default:  rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_div   <= DIV_RST;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_pen   <= 1'b0;
            rx_podd  <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            case (rx_state)
                RX_IDLE: if (rx_fall) begin
                    rx_div  <= div;
                    rx_pen  <= ctrl[2];
                    rx_podd <= ctrl[3];
                    rx_cnt  <= '0;
                    rx_bit  <= '0;
                end
                RX_START: rx_cnt <= rx_mid ? '0 : rx_cnt + ONE;
                RX_DATA: begin
                    if (rx_end) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + ONE;
                    end
                end
                RX_PAR, RX_STOP: rx_cnt <= rx_end ? '0 : rx_cnt + ONE;
                default: rx_cnt <= '0;
            endcase
        end
    end

    // ---------------- sticky flags and interrupt ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            int_o      <= 1'b0;
        end else begin
            // A new event in the same cycle as a clear keeps the flag set.
            rx_overrun <= set_ovr | (rx_overrun & ~(wr_stat & data_i[3]));
            frame_err  <= set_frm | (frame_err  & ~(wr_stat & data_i[4]));
            parity_err <= set_par | (parity_err & ~(wr_stat & data_i[5]));
            int_o      <= (ctrl[0] & rx_nonempty) | (ctrl[1] & tx_idle);
        end
    end

    always_comb begin
        data_o = '0;
        if (ce_i) begin
            case (word)
                2'd0: if (rx_nonempty) data_o = {24'b0, rx_head};
                2'd1: data_o = {26'b0, parity_err, frame_err, rx_overrun,
                                tx_idle, ~tx_full, rx_nonempty};
                2'd2: data_o = {28'b0, ctrl};
                default: data_o = {{(32-DIV_W){1'b0}}, div};
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed plus randomized bench for uart_mmio_fifo; a queue-based model
// tracks RX contents and sticky flags, TX frames are built from the byte value.
module tb_uart_mmio_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b0, we = 1'b0;
    logic [3:0]  addr = '0, sel = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq, txd;
    logic        rxd = 1'b1;

    int passed = 0, failed = 0, total = 0;

    logic [7:0] rxq[$];
    logic       m_ovr = 0, m_frm = 0, m_par = 0;
    logic [3:0] m_ctrl = '0;
    int         m_div = 96;
    logic       cap [0:255];

    uart_mmio_fifo #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .ce_i(ce), .we_i(we), .addr_i(addr),
        .data_i(wdata), .sel_i(sel), .data_o(rdata), .int_o(irq),
        .txd(txd), .rxd(rxd)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        ce = 1; we = 1; addr = a; wdata = d; sel = s;
        @(posedge clk);
        #1 ce = 0; we = 0; sel = '0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        ce = 1; we = 0; addr = a;
        #1 d = rdata;
        @(posedge clk);
        #1 ce = 0;
    endtask

    task automatic set_ctrl(input logic [3:0] c);
        bus_write(4'h8, {28'b0, c}, 4'b0001);
        m_ctrl = c;
    endtask

    task automatic set_div(input int d);
        bus_write(4'hC, d, 4'b0011);
        m_div = d;
    endtask

    function automatic logic [31:0] exp_status();
        return {26'b0, m_par, m_frm, m_ovr, 1'b1, 1'b1, rxq.size() != 0};
    endfunction

    function automatic logic par_of(input logic [7:0] b);
        return logic'($countones(b) % 2) ^ m_ctrl[3];
    endfunction

    task automatic check_status(input string tag);
        logic [31:0] d;
        bus_read(4'h4, d);
        check(tag, d, exp_status());
    endtask

    task automatic rx_bit(input logic v);
        rxd = v;
        repeat (m_div) @(posedge clk);
        #1;
    endtask

    // Serialise one frame onto rxd and update the model as the spec dictates.
    task automatic rx_send(input logic [7:0] b, input logic pbit, input logic stop);
        @(posedge clk); #1;
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(b[i]);
        if (m_ctrl[2]) rx_bit(pbit);
        rx_bit(stop);
        rxd = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        if (m_ctrl[2] && pbit != par_of(b)) m_par = 1;
        if (!stop) m_frm = 1;
        else if (rxq.size() < DEPTH) rxq.push_back(b);
        else m_ovr = 1;
    endtask

    task automatic rx_drain(input string tag);
        logic [31:0] d;
        while (rxq.size() != 0) begin
            bus_read(4'h0, d);
            check(tag, d, {24'b0, rxq.pop_front()});
        end
        bus_read(4'h0, d);
        check({tag, "_empty"}, d, 32'h0);
    endtask

    task automatic tx_capture(input int n, output logic ok);
        ok = 0;
        for (int t = 0; t < 400; t++) begin
            @(posedge clk); #1;
            if (txd === 1'b0) begin
                ok = 1;
                break;
            end
        end
        if (ok) begin
            cap[0] = txd;
            for (int k = 1; k < n; k++) begin
                @(posedge clk); #1;
                cap[k] = txd;
            end
        end
    endtask

    // Transmit nb (1 or 2) bytes back to back and check every sampled clock.
    task automatic tx_frames(input string tag, input logic [7:0] b0, input logic [7:0] b1, input int nb);
        logic ok;
        logic eb[$];
        logic [7:0] bb;
        int nbits;
        nbits = m_ctrl[2] ? 11 : 10;
        for (int f = 0; f < nb; f++) begin
            bb = (f == 0) ? b0 : b1;
            eb.push_back(1'b0);
            for (int i = 0; i < 8; i++) eb.push_back(bb[i]);
            if (m_ctrl[2]) eb.push_back(par_of(bb));
            eb.push_back(1'b1);
        end
        fork
            tx_capture(nb * nbits * m_div, ok);
            begin
                bus_write(4'h0, {24'b0, b0}, 4'b0001);
                if (nb > 1) bus_write(4'h0, {24'b0, b1}, 4'b0001);
            end
        join
        check({tag, "_start"}, {31'b0, ok}, 32'h1);
        if (ok) begin
            for (int j = 0; j < eb.size(); j++) begin
                logic [31:0] o;
                o = '0;
                for (int k = 0; k < m_div; k++) o[k] = cap[j * m_div + k];
                check($sformatf("%s_bit%0d", tag, j), o, eb[j] ? 32'((1 << m_div) - 1) : 32'h0);
            end
            @(posedge clk); #1;
            check({tag, "_idle_line"}, {31'b0, txd}, 32'h1);
            check_status({tag, "_status"});
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  b, b2;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", {31'b0, txd}, 32'h1);
        check("rst_int", {31'b0, irq}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        check_status("rst_status");
        bus_read(4'hC, d);  check("rst_div", d, 32'd96);
        bus_read(4'h8, d);  check("rst_ctrl", d, 32'h0);
        bus_read(4'h0, d);  check("rst_data_empty", d, 32'h0);
        @(negedge clk); ce = 0; addr = 4'h4;
        #1 check("no_ce_zero", rdata, 32'h0);

        // divisor lanes and lower clamp
        bus_write(4'hC, 32'h0, 4'b0011);
        bus_read(4'hC, d);  check("div_clamp", d, 32'd2);
        bus_write(4'hC, 32'h1234, 4'b0001);
        bus_read(4'hC, d);  check("div_lane0", d, 32'h0034);
        set_div(4);
        bus_read(4'hC, d);  check("div_4", d, 32'd4);

        // basic TX
        tx_frames("tx_a5", 8'hA5, 8'h00, 1);

        // TX idle interrupt
        set_ctrl(4'h2);
        @(posedge clk); #1;
        check("int_tx_idle", {31'b0, irq}, 32'h1);

        // basic RX with interrupt
        set_ctrl(4'h1);
        rx_send(8'h3C, 1'b0, 1'b1);
        check_status("rx_3c_status");
        check("int_rx", {31'b0, irq}, 32'h1);
        bus_read(4'h0, d);  check("rx_3c_data", d, {24'b0, rxq.pop_front()});
        check_status("rx_3c_popped");
        check("int_rx_clear", {31'b0, irq}, 32'h0);

        // overrun
        set_ctrl(4'h0);
        for (int i = 0; i <= DEPTH; i++) rx_send(8'(i), 1'b0, 1'b1);
        check_status("ovr_status");
        rx_drain("ovr_read");
        bus_write(4'h4, 32'h8, 4'b0001);
        m_ovr = 0;
        check_status("ovr_cleared");

        // odd parity TX and RX parity error
        set_ctrl(4'hC);
        tx_frames("tx_par", 8'h01, 8'h00, 1);
        rx_send(8'h01, 1'b1, 1'b1);
        check_status("par_err_status");
        rx_drain("par_read");
        bus_write(4'h4, 32'h20, 4'b0001);
        m_par = 0;

        // framing error, glitch
        set_ctrl(4'h0);
        rx_send(8'h55, 1'b0, 1'b0);
        check_status("frm_status");
        bus_write(4'h4, 32'h10, 4'b0001);
        m_frm = 0;
        @(posedge clk); #1 rxd = 1'b0;
        @(posedge clk); #1 rxd = 1'b1;
        repeat (12) @(posedge clk);
        check_status("glitch_status");

        // randomized traffic
        set_div($urandom_range(4, 8));
        for (int n = 0; n < 4; n++) begin
            set_ctrl({$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 2'b00});
            b = 8'($urandom_range(0, 255));
            b2 = 8'($urandom_range(0, 255));
            tx_frames($sformatf("rtx%0d", n), b, b2, (n % 2) + 1);
        end
        for (int n = 0; n < 8; n++) begin
            set_ctrl({$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 2'b00});
            b = 8'($urandom_range(0, 255));
            rx_send(b, $urandom_range(0, 1) == 1, $urandom_range(0, 4) != 0);
        end
        check_status("rrx_status");
        rx_drain("rrx_read");
        bus_write(4'h4, 32'h38, 4'b0001);
        m_ovr = 0; m_frm = 0; m_par = 0;
        check_status("rrx_cleared");

        // asynchronous reset during a frame
        set_ctrl(4'h0);
        bus_write(4'h0, 32'h00, 4'b0001);
        repeat (3 * m_div) @(posedge clk);
        #1 check("mid_tx_low", {31'b0, txd}, 32'h0);
        #2 rst_n = 1'b0;
        #1 check("reset_txd_async", {31'b0, txd}, 32'h1);
        @(negedge clk) rst_n = 1'b1;
        m_div = 96;
        check_status("post_reset_status");
        bus_read(4'hC, d);  check("post_reset_div", d, 32'd96);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
